sample_controller: RTL
======================

// Module: sample_controller
// PURPOSE
//  Sits directly downstream of the UART command decoder. Consumes its command strobes
//  (reset / sample / set-decimation / clean-memory + 4-bit param) and drives the sample
//  memory write port: decimated capture of ADC samples, or zero-fill of the whole memory.
//  Reports busy/done/rejected status back toward the host side.
// PARAMETERS
//  DATA_SIZE     8   width of i_cmd_param (only bits [3:0] used)
//  SAMPLE_WIDTH  14  width of i_sample / o_mem_data
//  ADDR_WIDTH    10  memory address width; MEM_DEPTH = 2**ADDR_WIDTH
// PORTS
//  i_clock          in   1             single clock, all logic on posedge
//  i_reset          in   1             synchronous, active-high reset
//  i_cmd_reset      in   1             command level (held several cycles by decoder)
//  i_cmd_sample     in   1             command level
//  i_cmd_set_decim  in   1             command level
//  i_cmd_clean_mem  in   1             command level
//  i_cmd_param      in   DATA_SIZE     decimation value in [3:0]
//  i_sample_valid   in   1             ADC sample strobe
//  i_sample         in   SAMPLE_WIDTH  ADC sample
//  o_mem_we         out  1             memory write enable
//  o_mem_addr       out  ADDR_WIDTH    memory write address
//  o_mem_data       out  SAMPLE_WIDTH  memory write data
//  o_busy           out  1             high in SAMPLE or CLEAN
//  o_done           out  1             1-cycle pulse on operation completion
//  o_rejected       out  1             1-cycle pulse: command ignored because busy
//  o_decim          out  4             current decimation setting
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; decim=0; decim_cnt=0; edge-detect history=0.
//  - Command lines are levels held multiple cycles; each acts once, on its rising edge
//    (cur=1, prev=0). Effect visible 1 cycle after the rising-edge cycle.
//  - Priority among simultaneous rising edges: reset > clean_mem > sample > set_decim.
//  - cmd_reset: any state -> IDLE, decim=0, addr=0, we=0; no o_done. Not rejectable.
//  - IDLE: set_decim -> decim=param[3:0]; sample -> SAMPLE, addr=0, decim_cnt=0;
//    clean_mem -> CLEAN, addr=0.
//  - SAMPLE/CLEAN: sample/clean/set_decim edges ignored, o_rejected pulses 1 cycle.
//  - SAMPLE: on i_sample_valid: if decim_cnt==0 -> registered write next cycle
//    (we=1, addr, data=i_sample), decim_cnt<=decim; else decim_cnt<=decim_cnt-1.
//    Keeps 1 of every decim+1 valid samples (decim=0 keeps all). addr increments after
//    each write; write to MEM_DEPTH-1 -> IDLE, o_done pulses same cycle as that write.
//  - CLEAN: we=1 every cycle, data=0, addr 0..MEM_DEPTH-1 (MEM_DEPTH cycles);
//    o_done with last write, then IDLE.
//  - o_mem_we is a 1-cycle pulse per write; addr/data stable whenever we=1.
//  - i_reset mid-operation: as reset above; partial memory contents left as-is.
// CONFIGURATION
//  SAMPLE_CTRL_WRAP_EN defined: SAMPLE does not stop at MEM_DEPTH-1; addr wraps to 0,
//    o_done pulses on every wrap, state stays SAMPLE until cmd_reset (circular capture).
//  Undefined: one-shot capture, stop at MEM_DEPTH-1 as above. CLEAN unaffected.
// STRUCTURE
//  - Package sample_ctrl_pkg: state encoding (IDLE=0, SAMPLE=1, CLEAN=2), command
//    index constants, DECIM_WIDTH=4.
//  - Sub-module cmd_edge_detect: registers the 4 command lines, outputs rising-edge
//    pulses; FSM + address/decim counters stay in sample_controller.
// TESTING
//  1. Reset, then sample cmd held 3 cycles, decim=0, 2**ADDR_WIDTH valid samples
//     (value=index) -> mem[i]=i, exactly MEM_DEPTH we pulses, one o_done, back to IDLE.
//  2. set_decim param=0x3, sample, valid samples 0..39 -> writes 0,4,8,..,36 to addr 0..9.
//  3. clean_mem from IDLE -> we=1 for MEM_DEPTH consecutive cycles, data=0,
//     addr 0..MEM_DEPTH-1, o_done on last, o_busy low next cycle.
//  4. During SAMPLE, issue clean_mem and set_decim=5 -> two o_rejected pulses,
//     o_decim unchanged, capture continues uninterrupted.
//  5. cmd_reset at addr=100 in SAMPLE -> IDLE next cycle, o_decim=0, no o_done, no we;
//     same with i_reset asserted mid-CLEAN.
//  6. WRAP_EN build: capture 2*MEM_DEPTH+5 samples -> two o_done pulses, addr=5,
//     o_busy=1; cmd_reset -> IDLE.

Source files
------------

// File: rtl/sample_ctrl_pkg.sv
// Shared definitions for the sample controller: FSM state encoding,
// command line indices and decimation counter width.
package sample_ctrl_pkg;

    // Controller operating state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_CLEAN  = 2'd2
    } state_t;

    // Bit positions of the command lines inside the packed command vector
    localparam int NUM_CMDS      = 4;
    localparam int CMD_RESET     = 0;
    localparam int CMD_SAMPLE    = 1;
    localparam int CMD_SET_DECIM = 2;
    localparam int CMD_CLEAN_MEM = 3;

    // Decimation setting / counter width
    localparam int DECIM_WIDTH = 4;

    // True when the controller owns the memory port
    function automatic logic state_is_busy(input state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/sample_controller_cmd_edge.sv
// Rising-edge detector for the decoder's command levels. The decoder holds
// each command for several cycles; downstream logic must act on it once.
module cmd_edge_detect
    import sample_ctrl_pkg::*;
(
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [NUM_CMDS-1:0] i_cmd,
    output logic [NUM_CMDS-1:0] o_rise
);

    logic [NUM_CMDS-1:0] cmd_prev;

    // Remember last cycle's command levels
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cmd_prev <= '0;
        end else begin
            cmd_prev <= i_cmd;
        end
    end

    assign o_rise = i_cmd & ~cmd_prev;

endmodule

// File: rtl/sample_controller.sv
// Sample controller: turns decoder command strobes into sample-memory writes.
// Captures decimated ADC samples or zero-fills the memory, and reports
// busy / done / rejected status.
// Build option SAMPLE_CTRL_WRAP_EN: capture wraps around the memory forever
// (o_done on every wrap) instead of stopping after the last address.
module sample_controller
    import sample_ctrl_pkg::*;
#(
    parameter int DATA_SIZE    = 8,
    parameter int SAMPLE_WIDTH = 14,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_cmd_reset,
    input  logic                    i_cmd_sample,
    input  logic                    i_cmd_set_decim,
    input  logic                    i_cmd_clean_mem,
    input  logic [DATA_SIZE-1:0]    i_cmd_param,
    input  logic                    i_sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] i_sample,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [SAMPLE_WIDTH-1:0] o_mem_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_rejected,
    output logic [DECIM_WIDTH-1:0]  o_decim
);

    localparam logic [ADDR_WIDTH-1:0]  ADDR_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [DECIM_WIDTH-1:0] DECIM_ONE = DECIM_WIDTH'(1);

    logic [NUM_CMDS-1:0] cmd_level;
    logic [NUM_CMDS-1:0] cmd_rise;
    logic                cmd_rejectable;
    logic                sample_stop;
    logic                unused_param_bits;

    state_t                  state_q,  state_n;
    logic [ADDR_WIDTH-1:0]   addr_q,   addr_n;
    logic [SAMPLE_WIDTH-1:0] data_q,   data_n;
    logic                    we_q,     we_n;
    logic                    done_q,   done_n;
    logic                    rej_q,    rej_n;
    logic [DECIM_WIDTH-1:0]  decim_q,  decim_n;
    logic [DECIM_WIDTH-1:0]  cnt_q,    cnt_n;

    assign cmd_level[CMD_RESET]     = i_cmd_reset;
    assign cmd_level[CMD_SAMPLE]    = i_cmd_sample;
    assign cmd_level[CMD_SET_DECIM] = i_cmd_set_decim;
    assign cmd_level[CMD_CLEAN_MEM] = i_cmd_clean_mem;

    // Only the low nibble of the parameter carries the decimation value
    assign unused_param_bits = ^i_cmd_param[DATA_SIZE-1:DECIM_WIDTH];

    cmd_edge_detect u_cmd_edge (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_cmd   (cmd_level),
        .o_rise  (cmd_rise)
    );

    // Commands that arrive while an operation is running are dropped
    assign cmd_rejectable = cmd_rise[CMD_SAMPLE] | cmd_rise[CMD_SET_DECIM] |
                            cmd_rise[CMD_CLEAN_MEM];

`ifdef SAMPLE_CTRL_WRAP_EN
    // Circular capture: never leave SAMPLE on our own
    assign sample_stop = 1'b0;
`else
    // One-shot capture: the cycle after the final write returns to IDLE
    assign sample_stop = done_q;
`endif

    // Next-state, counters and registered memory-port values
    always_comb begin
        state_n = state_q;
        // The write address advances once the current write has been presented
        addr_n  = we_q ? (addr_q + ADDR_ONE) : addr_q;
        data_n  = data_q;
        we_n    = 1'b0;
        done_n  = 1'b0;
        rej_n   = 1'b0;
        decim_n = decim_q;
        cnt_n   = cnt_q;

        if (cmd_rise[CMD_RESET]) begin
            state_n = ST_IDLE;
            decim_n = '0;
            addr_n  = '0;
            cnt_n   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_rise[CMD_CLEAN_MEM]) begin
                        state_n = ST_CLEAN;
                        addr_n  = '0;
                    end else if (cmd_rise[CMD_SAMPLE]) begin
                        state_n = ST_SAMPLE;
                        addr_n  = '0;
                        cnt_n   = '0;
                    end else if (cmd_rise[CMD_SET_DECIM]) begin
                        decim_n = i_cmd_param[DECIM_WIDTH-1:0];
                    end
                end

                ST_SAMPLE: begin
                    rej_n = cmd_rejectable;
                    if (sample_stop) begin
                        state_n = ST_IDLE;
                    end else if (i_sample_valid) begin
                        if (cnt_q == '0) begin
                            we_n   = 1'b1;
                            data_n = i_sample;
                            cnt_n  = decim_q;
                            done_n = (addr_n == ADDR_LAST);
                        end else begin
                            cnt_n = cnt_q - DECIM_ONE;
                        end
                    end
                end

                ST_CLEAN: begin
                    rej_n = cmd_rejectable;
                    if (done_q) begin
                        state_n = ST_IDLE;
                    end else begin
                        we_n   = 1'b1;
                        data_n = '0;
                        done_n = (addr_n == ADDR_LAST);
                    end
                end

                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            rej_q   <= 1'b0;
            decim_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            we_q    <= we_n;
            done_q  <= done_n;
            rej_q   <= rej_n;
            decim_q <= decim_n;
            cnt_q   <= cnt_n;
        end
    end

    assign o_mem_we   = we_q;
    assign o_mem_addr = addr_q;
    assign o_mem_data = data_q;
    assign o_busy     = state_is_busy(state_q);
    assign o_done     = done_q;
    assign o_rejected = rej_q;
    assign o_decim    = decim_q;

endmodule
